// File: rtl/wdt_pkg.sv
// rtl/wdt_pkg.sv - shared state encoding and register map for the watchdog timer
package wdt_pkg;

    typedef enum logic [1:0] {
        WDT_IDLE    = 2'd0,
        WDT_COUNT   = 2'd1,
        WDT_EXPIRED = 2'd2
    } wdt_state_e;

    localparam logic [1:0] WDT_WDEN    = 2'd0;
    localparam logic [1:0] WDT_WDLIVE  = 2'd1;
    localparam logic [1:0] WDT_WTOCNT  = 2'd2;
    localparam logic [1:0] WDT_WTOSTAT = 2'd3;

endpackage

// File: rtl/wdt_prescaler.sv
// rtl/wdt_prescaler.sv - divides clk into watchdog ticks, one every PRESCALE cycles while running
module wdt_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q, pre_d;

    assign tick = run && (pre_q == LAST);

    // clear restarts the tick phase so a kick always grants a full period
    always_comb begin
        pre_d = pre_q;
        if (clear || tick) begin
            pre_d = '0;
        end else if (run) begin
            pre_d = pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/wdt_timer.sv
// rtl/wdt_timer.sv - watchdog timer with register window, drives the CSR timeout level
module wdt_timer
    import wdt_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_we,
    input  logic [1:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        timeout,
    output logic        wdt_active
);

    wdt_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wtocnt_q, wtocnt_d;
    logic             timeout_q, timeout_d;
    logic             pre_clear;
    logic             tick;
    logic             wden_wr;
    logic             kick;

    assign wden_wr = reg_we && (reg_addr == WDT_WDEN);
    assign kick    = reg_we && (reg_addr == WDT_WDLIVE) && reg_wdata[0];

    wdt_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (state_q == WDT_COUNT),
        .clear(pre_clear),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        wtocnt_d  = wtocnt_q;
        pre_clear = 1'b0;

        if (reg_we && (reg_addr == WDT_WTOCNT)) begin
            wtocnt_d = reg_wdata[CNT_W-1:0];
        end

        // disable overrides kick and expiry in the same cycle
        if (wden_wr && !reg_wdata[0]) begin
            state_d   = WDT_IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
            pre_clear = 1'b1;
        end else begin
            case (state_q)
                WDT_IDLE: begin
                    if (wden_wr) begin
                        state_d   = WDT_COUNT;
                        cnt_d     = '0;
                        pre_clear = 1'b1;
                    end
                end
                WDT_COUNT: begin
                    if (kick) begin
                        cnt_d     = '0;
                        pre_clear = 1'b1;
                    end else if (tick) begin
                        if (cnt_q == wtocnt_q) begin
                            state_d   = WDT_EXPIRED;
                            timeout_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                WDT_EXPIRED: begin
                    if (kick) begin
                        state_d   = WDT_COUNT;
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        pre_clear = 1'b1;
                    end
                end
                default: begin
                    state_d   = WDT_IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= WDT_IDLE;
            cnt_q     <= '0;
            wtocnt_q  <= '1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wtocnt_q  <= wtocnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            WDT_WDEN:    reg_rdata = {31'b0, state_q != WDT_IDLE};
            WDT_WDLIVE:  reg_rdata = '0;
            WDT_WTOCNT:  reg_rdata = 32'(wtocnt_q);
            WDT_WTOSTAT: reg_rdata = {timeout_q, state_q, 29'(cnt_q)};
            default:     reg_rdata = '0;
        endcase
    end

    assign timeout    = timeout_q;
    assign wdt_active = (state_q == WDT_COUNT) || (state_q == WDT_EXPIRED);

endmodule

// File: tb/tb_wdt_timer.sv
// tb/tb_wdt_timer.sv - scoreboard bench for wdt_timer at PRESCALE 1 and 4
module tb_wdt_timer;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst4;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] rd0, rd4;
    logic        to0, to4;
    logic        act0, act4;

    int   total = 0;
    int   bad   = 0;
    logic exp_q[$];
    logic e;
    int   edge_n;

    always #5 clk = ~clk;

    wdt_timer #(.CNT_W(32), .PRESCALE(1)) u0 (
        .clk(clk), .rst(rst0), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(rd0), .timeout(to0), .wdt_active(act0)
    );

    wdt_timer #(.CNT_W(32), .PRESCALE(4)) u4 (
        .clk(clk), .rst(rst4), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(rd4), .timeout(to4), .wdt_active(act4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        step();
        reg_we    = 1'b0;
        reg_wdata = '0;
        reg_addr  = 2'd3;
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b0; rst4 = 1'b0;
        reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = '0;
        repeat (3) step();
        total++;
        if (to0 !== 1'b0 || to4 !== 1'b0) begin
            bad++; $display("FAIL reset_timeout got=%b/%b want=0/0", to0, to4);
        end
        rst0 = 1'b1; rst4 = 1'b1;
        step();
        reg_addr = 2'd3; #1;
        total++;
        if (rd0 !== 32'h0 || rd4 !== 32'h0) begin
            bad++; $display("FAIL reset_wtostat got=%h/%h want=00000000", rd0, rd4);
        end
        reg_addr = 2'd2; #1;
        total++;
        if (rd0 !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL reset_wtocnt got=%h want=ffffffff", rd0);
        end
        reg_addr = 2'd0; #1;
        total++;
        if (rd0 !== 32'h0 || act0 !== 1'b0) begin
            bad++; $display("FAIL reset_wden got=%h act=%b want=0 act=0", rd0, act0);
        end
    endtask

    task automatic test_expiry();
        do_write(2'd2, 32'd3);
        do_write(2'd0, 32'd1);
        total++;
        if (to0 !== 1'b0 || act0 !== 1'b1) begin
            bad++; $display("FAIL expiry_enable got to=%b act=%b want to=0 act=1", to0, act0);
        end
        for (int n = 1; n <= 23; n++) exp_q.push_back(n >= 4);
        edge_n = 0;
        while (exp_q.size() > 0) begin
            step(); edge_n++;
            e = exp_q.pop_front();
            total++;
            if (to0 !== e) begin
                bad++; $display("FAIL expiry_timeout E+%0d got=%b want=%b", edge_n, to0, e);
            end
        end
        reg_addr = 2'd3; #1;
        total++;
        if (rd0 !== 32'hC000_0003) begin
            bad++; $display("FAIL expiry_wtostat got=%h want=c0000003", rd0);
        end
    endtask

    task automatic test_kick();
        do_write(2'd0, 32'd0);
        total++;
        if (to0 !== 1'b0) begin
            bad++; $display("FAIL kick_disable got=%b want=0", to0);
        end
        do_write(2'd0, 32'd1);
        step();
        total++;
        if (to0 !== 1'b0) begin
            bad++; $display("FAIL kick_pre got=%b want=0", to0);
        end
        for (int k = 0; k < 10; k++) begin
            do_write(2'd1, 32'd1);
            total++;
            if (to0 !== 1'b0) begin
                bad++; $display("FAIL kick_hold k=%0d got=%b want=0", k, to0);
            end
            if (k == 0) begin
                total++;
                if (rd0 !== 32'h2000_0000) begin
                    bad++; $display("FAIL kick_wtostat got=%h want=20000000", rd0);
                end
            end
            if (k < 9) begin
                for (int s = 0; s < 2; s++) begin
                    step();
                    total++;
                    if (to0 !== 1'b0) begin
                        bad++; $display("FAIL kick_gap k=%0d s=%0d got=%b want=0", k, s, to0);
                    end
                end
            end
        end
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        edge_n = 0;
        while (exp_q.size() > 0) begin
            step(); edge_n++;
            e = exp_q.pop_front();
            total++;
            if (to0 !== e) begin
                bad++; $display("FAIL kick_stop L+%0d got=%b want=%b", edge_n, to0, e);
            end
        end
    endtask

    task automatic test_expired_exit();
        do_write(2'd0, 32'd0);
        do_write(2'd0, 32'd1);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(1'b0); exp_q.push_back(1'b0);
            exp_q.push_back(1'b0); exp_q.push_back(1'b1);
            edge_n = 0;
            while (exp_q.size() > 0) begin
                step(); edge_n++;
                e = exp_q.pop_front();
                total++;
                if (to0 !== e) begin
                    bad++; $display("FAIL exit_reexpire r=%0d +%0d got=%b want=%b", r, edge_n, to0, e);
                end
            end
            if (r == 0) begin
                do_write(2'd1, 32'd1);
                total++;
                if (to0 !== 1'b0 || rd0 !== 32'h2000_0000) begin
                    bad++; $display("FAIL exit_kick got to=%b stat=%h want to=0 stat=20000000", to0, rd0);
                end
            end
        end
        do_write(2'd0, 32'd0);
        total++;
        if (to0 !== 1'b0 || rd0 !== 32'h0 || act0 !== 1'b0) begin
            bad++; $display("FAIL exit_disable got to=%b stat=%h act=%b want 0/00000000/0", to0, rd0, act0);
        end
    endtask

    task automatic test_kick_vs_expiry();
        do_write(2'd2, 32'd2);
        do_write(2'd0, 32'd1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        edge_n = 0;
        while (exp_q.size() > 0) begin
            step(); edge_n++;
            e = exp_q.pop_front();
            total++;
            if (to0 !== e) begin
                bad++; $display("FAIL race_pre E+%0d got=%b want=%b", edge_n, to0, e);
            end
        end
        do_write(2'd1, 32'd1);
        total++;
        if (to0 !== 1'b0) begin
            bad++; $display("FAIL race_kick_wins got=%b want=0", to0);
        end
        exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        edge_n = 3;
        while (exp_q.size() > 0) begin
            step(); edge_n++;
            e = exp_q.pop_front();
            total++;
            if (to0 !== e) begin
                bad++; $display("FAIL race_post E+%0d got=%b want=%b", edge_n, to0, e);
            end
        end
    endtask

    task automatic test_boundary();
        do_write(2'd0, 32'd0);
        do_write(2'd2, 32'd0);
        do_write(2'd0, 32'd1);
        total++;
        if (to0 !== 1'b0) begin
            bad++; $display("FAIL zero_enable got=%b want=0", to0);
        end
        step();
        total++;
        if (to0 !== 1'b1) begin
            bad++; $display("FAIL zero_first_tick got=%b want=1", to0);
        end
        reg_addr = 2'd2; #1;
        total++;
        if (rd0 !== 32'h0) begin
            bad++; $display("FAIL zero_wtocnt got=%h want=00000000", rd0);
        end
        do_write(2'd0, 32'd0);
        do_write(2'd2, 32'd3);
        do_write(2'd0, 32'd1);
        step(); step();
        do_write(2'd0, 32'd1);
        total++;
        if (to0 !== 1'b0) begin
            bad++; $display("FAIL reenable_e3 got=%b want=0", to0);
        end
        step();
        total++;
        if (to0 !== 1'b1) begin
            bad++; $display("FAIL reenable_no_restart got=%b want=1", to0);
        end
    endtask

    task automatic test_prescale();
        rst4 = 1'b0; step(); rst4 = 1'b1; step();
        do_write(2'd2, 32'd1);
        do_write(2'd0, 32'd1);
        total++;
        if (act4 !== 1'b1) begin
            bad++; $display("FAIL ps_active got=%b want=1", act4);
        end
        for (int n = 1; n <= 8; n++) exp_q.push_back(n == 8);
        edge_n = 0;
        while (exp_q.size() > 0) begin
            step(); edge_n++;
            e = exp_q.pop_front();
            total++;
            if (to4 !== e) begin
                bad++; $display("FAIL ps_expiry E+%0d got=%b want=%b", edge_n, to4, e);
            end
        end
        #2 rst4 = 1'b0;
        #1;
        total++;
        if (to4 !== 1'b0) begin
            bad++; $display("FAIL ps_async_drop got=%b want=0", to4);
        end
        step(); rst4 = 1'b1; step();
        do_write(2'd2, 32'd1);
        do_write(2'd0, 32'd1);
        repeat (5) step();
        #2 rst4 = 1'b0;
        #1;
        total++;
        if (to4 !== 1'b0 || rd4 !== 32'h0) begin
            bad++; $display("FAIL ps_mid_reset got to=%b stat=%h want 0/00000000", to4, rd4);
        end
        step(); step(); rst4 = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            total++;
            if (to4 !== 1'b0) begin
                bad++; $display("FAIL ps_after_reset n=%0d got=%b want=0", n, to4);
            end
        end
        reg_addr = 2'd3; #1;
        total++;
        if (rd4 !== 32'h0 || act4 !== 1'b0) begin
            bad++; $display("FAIL ps_idle got stat=%h act=%b want 00000000/0", rd4, act4);
        end
        do_write(2'd2, 32'd1);
        do_write(2'd0, 32'd1);
        for (int n = 1; n <= 8; n++) exp_q.push_back(n == 8);
        edge_n = 0;
        while (exp_q.size() > 0) begin
            step(); edge_n++;
            e = exp_q.pop_front();
            total++;
            if (to4 !== e) begin
                bad++; $display("FAIL ps_reenable E+%0d got=%b want=%b", edge_n, to4, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_kick();
        test_expired_exit();
        test_kick_vs_expiry();
        test_boundary();
        test_prescale();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
